// File: rtl/sync_fifo_pkg.sv
// Shared types for the single-clock FIFO.
// The operation code is {read accepted, write accepted} and selects how the occupancy count moves.
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Register array for the FIFO: one write port and one registered read port.
// Only the read register is reset; the array itself keeps its contents.
module sync_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A read of the slot being written on the same edge returns the old word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, full/empty and
// programmable almost-full/almost-empty flags decoded from the count.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEVEL = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_en,
    input  logic [WIDTH-1:0] write_data,
    input  logic             r_en,
    output logic [WIDTH-1:0] read_data,
    output logic             afull,
    output logic             full,
    output logic             aempty,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_accept;
    logic          rd_accept;
    fifo_op_e      op;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A full FIFO still takes a write when the head leaves on the same edge.
    assign wr_accept = w_en && (!full || r_en);
    assign rd_accept = r_en && !empty;

    always_comb begin
        op       = fifo_op_e'({rd_accept, wr_accept});
        wr_ptr_d = wr_accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_accept ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case (op)
            OP_WRITE: count_d = count_q + CW'(1);
            OP_READ:  count_d = count_q - CW'(1);
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (write_data),
        .re_i    (rd_accept),
        .raddr_i (rd_ptr_q),
        .rdata_o (read_data)
    );

    assign full   = (count_q == CW'(DEPTH));
    assign afull  = (count_q >= CW'(DEPTH - LEVEL));
    assign empty  = (count_q == '0);
    assign aempty = (count_q <= CW'(LEVEL));

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_sync_fifo;

    localparam int DEPTH = 8;
    localparam int LEVEL = 2;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             w_en;
    logic [WIDTH-1:0] write_data;
    logic             r_en;
    logic [WIDTH-1:0] read_data;
    logic             afull, full, aempty, empty;

    int               total = 0;
    int               bad   = 0;
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] rd_m;
    logic [WIDTH-1:0] bytes [DEPTH];

    always #5 clk = ~clk;

    sync_fifo #(.DEPTH(DEPTH), .LEVEL(LEVEL), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .w_en       (w_en),
        .write_data (write_data),
        .r_en       (r_en),
        .read_data  (read_data),
        .afull      (afull),
        .full       (full),
        .aempty     (aempty),
        .empty      (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, "/read_data"}, read_data, rd_m);
        chk({tag, "/full"},   full,   n == DEPTH);
        chk({tag, "/afull"},  afull,  n >= DEPTH - LEVEL);
        chk({tag, "/empty"},  empty,  n == 0);
        chk({tag, "/aempty"}, aempty, n <= LEVEL);
    endtask

    // One clock with the given request; the model applies FIFO rules on the
    // pre-edge occupancy, then all outputs are compared after the edge.
    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r, input string tag);
        bit was_full, was_empty;
        w_en = w; write_data = d; r_en = r;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (r && !was_empty) rd_m = q.pop_front();
        if (w && (!was_full || r)) q.push_back(d);
        #1;
        check_all(tag);
        w_en = 1'b0; r_en = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #2;
        q.delete();
        rd_m = '0;
        check_all(tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_all({tag, "_rel"});
    endtask

    task automatic fill(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            bytes[i] = WIDTH'($urandom);
            cyc(1'b1, bytes[i], 1'b0, tag);
        end
    endtask

    initial begin
        reset = 1'b0; w_en = 1'b0; r_en = 1'b0; write_data = '0;
        rd_m = '0;
        #3;
        do_reset("reset");
        chk("reset/rd0", read_data, 0);

        // Fill and watch thresholds against fixed values.
        for (int i = 0; i < DEPTH; i++) begin
            bytes[i] = WIDTH'($urandom);
            cyc(1'b1, bytes[i], 1'b0, "fill");
            if (i == 1) chk("fill/aempty_after2", aempty, 1);
            if (i == 2) chk("fill/aempty_after3", aempty, 0);
            if (i == 4) chk("fill/afull_after5", afull, 0);
            if (i == 5) chk("fill/afull_after6", afull, 1);
            if (i == 6) chk("fill/full_after7", full, 0);
            if (i == 7) chk("fill/full_after8", full, 1);
        end

        // Read and write together at full.
        cyc(1'b1, 8'hFF, 1'b1, "rw_full");
        chk("rw_full/head", read_data, bytes[0]);
        chk("rw_full/full", full, 1);
        for (int i = 1; i < DEPTH; i++) begin
            cyc(1'b0, '0, 1'b1, "drain1");
            chk("drain1/order", read_data, bytes[i]);
        end
        cyc(1'b0, '0, 1'b1, "drain1");
        chk("drain1/ff", read_data, 8'hFF);
        chk("drain1/empty", empty, 1);

        // r_en held DEPTH+1 cycles from full.
        fill("fill2");
        for (int i = 0; i <= DEPTH; i++) begin
            cyc(1'b0, '0, 1'b1, "drain2");
            chk("drain2/order", read_data, bytes[(i < DEPTH) ? i : DEPTH - 1]);
        end
        chk("drain2/empty", empty, 1);
        chk("drain2/aempty", aempty, 1);

        // Partial occupancy with simultaneous read/write and pointer wrap.
        do_reset("reset2");
        for (int i = 0; i < 4; i++) begin
            bytes[i] = WIDTH'($urandom);
            cyc(1'b1, bytes[i], 1'b0, "part");
        end
        cyc(1'b1, 8'hFF, 1'b1, "part_rw");
        chk("part_rw/head", read_data, bytes[0]);
        chk("part_rw/aempty", aempty, 0);
        chk("part_rw/afull", afull, 0);
        for (int i = 1; i < 4; i++) begin
            cyc(1'b0, '0, 1'b1, "part_drain");
            chk("part_drain/order", read_data, bytes[i]);
        end
        cyc(1'b0, '0, 1'b1, "part_drain");
        chk("part_drain/ff", read_data, 8'hFF);
        chk("part_drain/empty", empty, 1);

        // Write on full without read is dropped.
        fill("fill3");
        cyc(1'b1, 8'h5A, 1'b0, "drop");
        chk("drop/full", full, 1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, '0, 1'b1, "drop_drain");
            chk("drop_drain/order", read_data, bytes[i]);
        end
        chk("drop_drain/empty", empty, 1);

        // Read+write on empty: write lands, read ignored, no bypass.
        cyc(1'b1, 8'h33, 1'b1, "empty_rw");
        chk("empty_rw/hold", read_data, bytes[DEPTH-1]);
        chk("empty_rw/empty", empty, 0);
        cyc(1'b0, '0, 1'b1, "empty_rw_rd");
        chk("empty_rw_rd/data", read_data, 8'h33);

        // Random traffic with varying bias and a mid-run reset.
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = (i < 200) ? 70 : (i < 400) ? 30 : 50;
            if (i == 300) begin
                cyc(1'b1, WIDTH'($urandom), 1'b0, "rnd_pre_rst");
                do_reset("rnd_reset");
            end
            cyc(($urandom_range(99) < wp), WIDTH'($urandom), ($urandom_range(99) < 100 - wp), "rnd");
        end
        while (q.size() != 0) cyc(1'b0, '0, 1'b1, "final_drain");
        chk("final/empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
